// File: rtl/cp0_exception_unit.sv
// CP0 exception sequencer: captures Status/Cause/EPC, flushes the pipeline and redirects the PC
// to the handler on exception entry, and back to EPC on ERET.
module cp0_exception_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exception,
  input  logic [31:0] cause_in,
  input  logic [31:0] epc_in,
  input  logic        eret,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic        flush,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic        exl,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FLUSH, VECTOR, RETURN} state_t;

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;
  localparam logic [3:0] CNT_INIT    = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        flush_q, flush_d;
  logic        pc_sel_q, pc_sel_d;
  logic [31:0] pc_target_q, pc_target_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;

    if (cp0_we) begin
      case (cp0_waddr)
        ADDR_STATUS: status_d = cp0_wdata;
        ADDR_CAUSE:  cause_d  = cp0_wdata;
        ADDR_EPC:    epc_d    = cp0_wdata;
        default: ;
      endcase
    end

    // Hardware updates below override any MTC0 to the same register.
    case (state_q)
      IDLE: begin
        if (exception) begin
          cause_d  = cause_in;
          if (!status_q[1]) epc_d = epc_in;
          status_d = status_q | 32'h0000_0002;
          cnt_d    = CNT_INIT;
          state_d  = FLUSH;
        end else if (eret && status_q[1]) begin
          state_d = RETURN;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = VECTOR;
        else               cnt_d   = cnt_q - 4'd1;
      end
      VECTOR: state_d = IDLE;
      RETURN: begin
        status_d = status_q & ~32'h0000_0002;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    flush_d     = (state_d == FLUSH) || (state_d == RETURN);
    pc_sel_d    = (state_d == VECTOR) || (state_d == RETURN);
    pc_target_d = 32'h0;
    if (state_d == VECTOR)      pc_target_d = HANDLER_ADDR;
    else if (state_d == RETURN) pc_target_d = epc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      status_q    <= 32'h0;
      cause_q     <= 32'h0;
      epc_q       <= 32'h0;
      flush_q     <= 1'b0;
      pc_sel_q    <= 1'b0;
      pc_target_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      flush_q     <= flush_d;
      pc_sel_q    <= pc_sel_d;
      pc_target_q <= pc_target_d;
    end
  end

  always_comb begin
    case (cp0_raddr)
      ADDR_STATUS: cp0_rdata = status_q;
      ADDR_CAUSE:  cp0_rdata = cause_q;
      ADDR_EPC:    cp0_rdata = epc_q;
      default:     cp0_rdata = 32'h0;
    endcase
  end

  assign flush     = flush_q;
  assign pc_sel    = pc_sel_q;
  assign pc_target = pc_target_q;
  assign exl       = status_q[1];
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Bench for cp0_exception_unit: directed scenarios plus randomized ops against a trace-level model.
module tb_cp0_exception_unit;

  localparam logic [31:0] HANDLER = 32'h0000_0180;
  localparam int          FC      = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exception, eret, cp0_we;
  logic [31:0] cause_in, epc_in, cp0_wdata;
  logic [4:0]  cp0_waddr, cp0_raddr;
  logic [31:0] cp0_rdata, pc_target;
  logic        flush, pc_sel, exl, busy;

  int checks = 0;
  int errors = 0;

  logic [35:0] exp_q[$];
  logic [31:0] m_status, m_cause, m_epc;

  cp0_exception_unit #(.HANDLER_ADDR(HANDLER), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .exception(exception), .cause_in(cause_in),
    .epc_in(epc_in), .eret(eret), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
    .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
    .flush(flush), .pc_sel(pc_sel), .pc_target(pc_target), .exl(exl), .busy(busy)
  );

  always #5 clk = ~clk;

  // Observed output vector: {flush, pc_sel, busy, exl, pc_target}
  function automatic logic [35:0] obs();
    return {flush, pc_sel, busy, exl, pc_target};
  endfunction

  function automatic logic [35:0] ov(input logic f, input logic p, input logic b,
                                     input logic x, input logic [31:0] t);
    return {f, p, b, x, t};
  endfunction

  // Expected cycles after an accepted exception: flush for FC cycles, one vector cycle, idle.
  function automatic void push_entry();
    for (int i = 0; i < FC; i++) exp_q.push_back(ov(1, 0, 1, 1, 32'h0));
    exp_q.push_back(ov(0, 1, 1, 1, HANDLER));
    exp_q.push_back(ov(0, 0, 0, 1, 32'h0));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exception = 0; eret = 0; cp0_we = 0;
    cause_in = 0; epc_in = 0; cp0_waddr = 0; cp0_wdata = 0;
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
    cp0_raddr = a;
    #1;
    d = cp0_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    clear_inputs();
    cp0_raddr = 0;
    rst_n = 0;
    tick(); tick();
    checks++;
    if (obs() !== 36'h0) begin errors++; $display("FAIL reset_outputs got %h expected %h", obs(), 36'h0); end
    for (int a = 12; a <= 14; a++) begin
      read_reg(5'(a), d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h expected 0", a, d); end
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_overflow_entry();
    logic [31:0] d;
    exception = 1; cause_in = 32'd4; epc_in = 32'h0040_0010;
    tick();
    clear_inputs();
    exp_q.delete();
    push_entry();
    foreach (exp_q[i]) begin
      if (i > 0) tick();
      checks++;
      if (obs() !== exp_q[i]) begin errors++; $display("FAIL entry_cycle%0d got %h expected %h", i, obs(), exp_q[i]); end
    end
    read_reg(5'd14, d);
    checks++;
    if (d !== 32'h0040_0010) begin errors++; $display("FAIL entry_epc got %h expected 00400010", d); end
    read_reg(5'd13, d);
    checks++;
    if (d !== 32'd4) begin errors++; $display("FAIL entry_cause got %h expected 4", d); end
  endtask

  task automatic test_return();
    eret = 1;
    tick();
    clear_inputs();
    checks++;
    if (obs() !== ov(1, 1, 1, 1, 32'h0040_0010)) begin
      errors++; $display("FAIL return_cycle got %h expected %h", obs(), ov(1, 1, 1, 1, 32'h0040_0010));
    end
    tick();
    checks++;
    if (obs() !== 36'h0) begin errors++; $display("FAIL return_done got %h expected 0", obs()); end
  endtask

  task automatic test_nested();
    logic [31:0] d;
    exception = 1; cause_in = 32'd4; epc_in = 32'h0040_0010;
    tick(); clear_inputs();
    for (int i = 0; i < FC + 1; i++) tick();
    exception = 1; cause_in = 32'd1; epc_in = 32'h0000_0200;
    tick(); clear_inputs();
    exp_q.delete();
    push_entry();
    foreach (exp_q[i]) begin
      if (i > 0) tick();
      checks++;
      if (obs() !== exp_q[i]) begin errors++; $display("FAIL nested_cycle%0d got %h expected %h", i, obs(), exp_q[i]); end
    end
    read_reg(5'd14, d);
    checks++;
    if (d !== 32'h0040_0010) begin errors++; $display("FAIL nested_epc got %h expected 00400010", d); end
    read_reg(5'd13, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL nested_cause got %h expected 1", d); end
    eret = 1; tick(); clear_inputs(); tick();
  endtask

  task automatic test_conflicts();
    logic [31:0] d;
    // eret with exl clear: nothing happens
    eret = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== 36'h0) begin errors++; $display("FAIL eret_noexl_cycle%0d got %h expected 0", i, obs()); end
    end
    clear_inputs();
    // exception and eret together, then more requests during the busy sequence
    exception = 1; eret = 1; cause_in = 32'd2; epc_in = 32'h0000_0300;
    tick();
    exception = 1; eret = 1; cause_in = 32'd7; epc_in = 32'h0000_0999;
    exp_q.delete();
    push_entry();
    foreach (exp_q[i]) begin
      if (i > 0) tick();
      if (i == exp_q.size() - 2) clear_inputs();
      checks++;
      if (obs() !== exp_q[i]) begin errors++; $display("FAIL conflict_cycle%0d got %h expected %h", i, obs(), exp_q[i]); end
    end
    clear_inputs();
    read_reg(5'd13, d);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL conflict_cause got %h expected 2", d); end
    read_reg(5'd14, d);
    checks++;
    if (d !== 32'h0000_0300) begin errors++; $display("FAIL conflict_epc got %h expected 00000300", d); end
    eret = 1; tick(); clear_inputs(); tick();
  endtask

  task automatic test_mtc0();
    logic [31:0] d;
    cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
    tick(); clear_inputs();
    read_reg(5'd14, d);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mtc0_epc got %h expected deadbeef", d); end
    cp0_we = 1; cp0_waddr = 5'd5; cp0_wdata = 32'h1234_5678;
    tick(); clear_inputs();
    read_reg(5'd5, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mfc0_addr5 got %h expected 0", d); end
    cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'h1234_5678;
    exception = 1; cause_in = 32'd1; epc_in = 32'h0000_0500;
    tick(); clear_inputs();
    for (int i = 0; i < FC + 1; i++) tick();
    read_reg(5'd14, d);
    checks++;
    if (d !== 32'h0000_0500) begin errors++; $display("FAIL mtc0_vs_exc_epc got %h expected 00000500", d); end
    eret = 1; tick(); clear_inputs(); tick();
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    exception = 1; cause_in = 32'd4; epc_in = 32'h0000_0040;
    tick(); clear_inputs();
    #3;
    rst_n = 0;
    #1;
    checks++;
    if (obs() !== 36'h0) begin errors++; $display("FAIL async_reset got %h expected 0", obs()); end
    read_reg(5'd14, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL async_reset_epc got %h expected 0", d); end
    tick();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs() !== 36'h0) begin errors++; $display("FAIL post_reset_quiet%0d got %h expected 0", i, obs()); end
    end
    // exception on the very first edge after release
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    exception = 1; cause_in = 32'd4; epc_in = 32'h0000_0040;
    tick(); clear_inputs();
    exp_q.delete();
    push_entry();
    foreach (exp_q[i]) begin
      if (i > 0) tick();
      checks++;
      if (obs() !== exp_q[i]) begin errors++; $display("FAIL first_edge_cycle%0d got %h expected %h", i, obs(), exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, c, e, wd;
    logic        ex, er, we, old_exl;
    logic [4:0]  wa;
    rst_n = 0; clear_inputs(); #2; @(negedge clk); rst_n = 1;
    m_status = 0; m_cause = 0; m_epc = 0;
    for (int n = 0; n < 80; n++) begin
      ex = ($urandom_range(0, 2) == 0);
      er = $urandom_range(0, 1) == 1;
      we = $urandom_range(0, 1) == 1;
      wa = 5'($urandom_range(10, 16));
      wd = $urandom; c = $urandom; e = $urandom;
      exception = ex; eret = er; cp0_we = we; cp0_waddr = wa; cp0_wdata = wd;
      cause_in = c; epc_in = e;
      tick();
      clear_inputs();
      old_exl = m_status[1];
      exp_q.delete();
      if (ex) begin
        m_cause = c;
        if (!old_exl) m_epc = e;
        else if (we && wa == 5'd14) m_epc = wd;
        m_status = m_status | 32'h2;
        push_entry();
      end else begin
        if (we && wa == 5'd12) m_status = wd;
        if (we && wa == 5'd13) m_cause  = wd;
        if (we && wa == 5'd14) m_epc    = wd;
        if (er && old_exl) begin
          exp_q.push_back(ov(1, 1, 1, m_status[1], m_epc));
          m_status[1] = 1'b0;
        end
        exp_q.push_back(ov(0, 0, 0, m_status[1], 32'h0));
      end
      foreach (exp_q[i]) begin
        if (i > 0) tick();
        checks++;
        if (obs() !== exp_q[i]) begin errors++; $display("FAIL rand%0d_cycle%0d got %h expected %h", n, i, obs(), exp_q[i]); end
        clear_inputs();
        if (i + 1 < exp_q.size() - 1 || (i + 1 == exp_q.size() - 1 && exp_q[i][33])) begin
          exception = $urandom_range(0, 1) == 1; eret = $urandom_range(0, 1) == 1;
          cause_in = $urandom; epc_in = $urandom;
          cp0_we = 1; cp0_waddr = 5'($urandom_range(0, 11)); cp0_wdata = $urandom;
        end
      end
      clear_inputs();
      read_reg(5'd12, d);
      checks++;
      if (d !== m_status) begin errors++; $display("FAIL rand%0d_status got %h expected %h", n, d, m_status); end
      read_reg(5'd13, d);
      checks++;
      if (d !== m_cause) begin errors++; $display("FAIL rand%0d_cause got %h expected %h", n, d, m_cause); end
      read_reg(5'd14, d);
      checks++;
      if (d !== m_epc) begin errors++; $display("FAIL rand%0d_epc got %h expected %h", n, d, m_epc); end
    end
  endtask

  initial begin
    test_reset();
    test_overflow_entry();
    test_return();
    test_nested();
    test_conflicts();
    test_mtc0();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_exception_unit.md
CP0_EXCEPTION_UNIT -- requirements
Module: cp0_exception_unit

Interface
REQ-001 SHALL have parameter HANDLER_ADDR, default 32'h0000_0180: exception vector driven on pc_target.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2: cycles flush is held per exception entry (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port exception  input  1  exception request from the detector.
REQ-006 SHALL have port cause_in  input  32  cause bitmask (bit0 illegal inst, bit1 ALU ctrl, bit2 overflow).
REQ-007 SHALL have port epc_in  input  32  faulting-instruction PC.
REQ-008 SHALL have port eret  input  1  return-from-exception request.
REQ-009 SHALL have ports cp0_we/cp0_waddr/cp0_wdata  input  1/5/32  MTC0 write port.
REQ-010 SHALL have ports cp0_raddr  input  5  and cp0_rdata  output  32  MFC0 read port.
REQ-011 SHALL have ports flush  output  1, pc_sel  output  1, pc_target  output  32  pipeline flush and PC override.
REQ-012 SHALL have ports exl  output  1 (Status[1]) and busy  output  1 (FSM not IDLE).

Function
REQ-013 SHALL hold registers Status (addr 12), Cause (addr 13), EPC (addr 14), each 32 bits.
REQ-014 FSM SHALL have states IDLE, FLUSH, VECTOR, RETURN; busy=1 in any state except IDLE.
REQ-015 IDLE, exception=1: Cause<=cause_in; EPC<=epc_in only if exl=0, else EPC held; Status[1]<=1; ->FLUSH; counter<=FLUSH_CYCLES-1.
REQ-016 FLUSH: flush=1; counter decrements each cycle; at counter=0 ->VECTOR; flush high exactly FLUSH_CYCLES cycles.
REQ-017 VECTOR: pc_sel=1, pc_target=HANDLER_ADDR for exactly one cycle; ->IDLE.
REQ-018 IDLE, eret=1, exception=0, exl=1: ->RETURN; eret with exl=0 SHALL be ignored.
REQ-019 RETURN: flush=1, pc_sel=1, pc_target=EPC for one cycle; Status[1]<=0 on that edge; ->IDLE.
REQ-020 exception and eret both high in IDLE: exception SHALL win; eret dropped.
REQ-021 exception or eret while busy=1 SHALL be ignored (no register change, no state change).
REQ-022 MTC0 (cp0_we=1) to 12/13/14 SHALL write on the edge; other addresses ignored.
REQ-023 MTC0 in the same cycle as exception capture or RETURN's Status update: hardware update SHALL win for the affected register; unaffected registers take the write.
REQ-024 cp0_rdata SHALL be combinational: Status/Cause/EPC for 12/13/14, 32'h0 otherwise; no write-through bypass.
REQ-025 flush, pc_sel SHALL be 0 and pc_target SHALL be 32'h0 in IDLE.
REQ-026 exl SHALL equal Status[1] at all times.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, Status=Cause=EPC=0, counter=0, flush=pc_sel=exl=busy=0, pc_target=0, regardless of clock.
REQ-028 Reset asserted mid-FLUSH/VECTOR/RETURN SHALL abort the sequence; no pc_sel pulse after release.
REQ-029 First exception SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-030 Overflow entry: exception=1, cause_in=4, epc_in=0x0040_0010 in IDLE -> flush high 2 cycles, then pc_sel=1/pc_target=0x180 one cycle; EPC=0x0040_0010, Cause=4, exl=1.
REQ-031 Return: after REQ-030, eret=1 -> next cycle flush=1, pc_sel=1, pc_target=0x0040_0010; following cycle exl=0, busy=0.
REQ-032 Nested: exl=1, exception with epc_in=0x0000_0200 -> EPC stays 0x0040_0010, Cause updated, vector sequence repeats.
REQ-033 Conflicts: exception+eret together in IDLE -> entry sequence only; eret with exl=0 -> no output activity; exception during FLUSH -> ignored.
REQ-034 MTC0/MFC0: write 0xDEAD_BEEF to addr 14 -> cp0_rdata(14)=0xDEAD_BEEF next cycle; write same cycle as exception -> EPC=epc_in; read addr 5 -> 0.
REQ-035 Async reset: drop rst_n mid-FLUSH between clock edges -> all outputs 0 immediately; no pc_sel pulse after release.
